// File: rtl/maxpool2d.sv
// ---------------------------------------------------------------------------
// maxpool2d
//
// Non-overlapping POOL_SIZE x POOL_SIZE max pooling over a signed 16-bit
// feature map stored channel-major, row-major within a channel. Elements are
// fetched one at a time through a single-outstanding read port. Each pooled
// value, optionally clamped at zero, is written out with its linear output
// address c*OH*OW + orow*OW + ocol. A pass starts on a start pulse taken in
// IDLE and ends with a one-cycle done pulse.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high
//   start        begin a pass (only looked at in IDLE)
//   fm_rd_en     one-cycle read request
//   fm_addr      read address, held while the read is outstanding
//   fm_data      signed read data
//   fm_rd_valid  fm_data qualifier (only looked at in WAIT)
//   pool_data    signed pooled value
//   pool_addr    output address of pool_data
//   pool_valid   one-cycle write strobe for pool_data/pool_addr
//   busy         high while a pass is in progress
//   done         one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module maxpool2d #(
   parameter int INPUT_WIDTH  = 62,
   parameter int INPUT_HEIGHT = 62,
   parameter int NUM_CHANNELS = 30,
   parameter int POOL_SIZE    = 2,
   parameter int RELU         = 1,
   localparam int OW    = INPUT_WIDTH / POOL_SIZE,
   localparam int OH    = INPUT_HEIGHT / POOL_SIZE,
   localparam int FM_N  = INPUT_WIDTH * INPUT_HEIGHT * NUM_CHANNELS,
   localparam int PO_N  = OW * OH * NUM_CHANNELS,
   localparam int FM_AW = (FM_N > 1) ? $clog2(FM_N) : 1,
   localparam int PO_AW = (PO_N > 1) ? $clog2(PO_N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             fm_rd_en,
   output logic [FM_AW-1:0] fm_addr,
   input  logic [15:0]      fm_data,
   input  logic             fm_rd_valid,
   output logic [15:0]      pool_data,
   output logic [PO_AW-1:0] pool_addr,
   output logic             pool_valid,
   output logic             busy,
   output logic             done
);

   // Counter widths, each at least one bit wide.
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1;
   localparam int COL_W = (OW > 1) ? $clog2(OW) : 1;
   localparam int K_W   = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

   localparam logic [CH_W-1:0]  C_LAST   = CH_W'(NUM_CHANNELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OH - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OW - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(POOL_SIZE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t state_reg, state_next;

   // Position counters: channel, output row/col, offset inside the window.
   logic [CH_W-1:0]  c_reg,    c_next;
   logic [ROW_W-1:0] orow_reg, orow_next;
   logic [COL_W-1:0] ocol_reg, ocol_next;
   logic [K_W-1:0]   kr_reg,   kr_next;
   logic [K_W-1:0]   kc_reg,   kc_next;

   logic signed [15:0] max_reg, max_next;
   logic [15:0]        pool_data_reg, pool_data_next;
   logic [PO_AW-1:0]   pool_addr_reg, pool_addr_next;
   logic [FM_AW-1:0]   fm_addr_reg,   fm_addr_next;

   logic win_first;
   logic win_last;
   logic kc_last;
   logic pass_last;

   logic signed [15:0] max_cand;
   logic [15:0]        pooled;
   logic [PO_AW-1:0]   out_addr;
   logic [FM_AW-1:0]   fm_row_next;
   logic [FM_AW-1:0]   fm_col_next;

   assign kc_last   = (kc_reg == K_LAST);
   assign win_first = (kr_reg == '0) && (kc_reg == '0);
   assign win_last  = (kr_reg == K_LAST) && kc_last;
   assign pass_last = (c_reg == C_LAST) && (orow_reg == ROW_LAST) &&
                      (ocol_reg == COL_LAST);

   // Running max including the element currently on fm_data. The first
   // element of a window loads unconditionally; later ones need a strictly
   // greater value, so ties keep the earlier element.
   always_comb begin
      max_cand = max_reg;
      if (win_first || ($signed(fm_data) > max_reg)) begin
         max_cand = $signed(fm_data);
      end
   end

   generate
      if (RELU != 0) begin : g_relu
         assign pooled = max_cand[15] ? 16'd0 : max_cand;
      end else begin : g_raw
         assign pooled = max_cand;
      end
   endgenerate

   assign out_addr = PO_AW'(c_reg) * PO_AW'(OH * OW) +
                     PO_AW'(orow_reg) * PO_AW'(OW) +
                     PO_AW'(ocol_reg);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (fm_rd_valid) begin
               state_next = win_last ? ST_WRITE : ST_ISSUE;
            end
         end
         ST_WRITE: begin
            state_next = pass_last ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs decoded from the current state
   // ------------------------------------------------------------------
   always_comb begin
      fm_rd_en   = 1'b0;
      pool_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_ISSUE: begin
            fm_rd_en = 1'b1;
            busy     = 1'b1;
         end
         ST_WAIT: begin
            busy = 1'b1;
         end
         ST_WRITE: begin
            pool_valid = 1'b1;
            busy       = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      c_next         = c_reg;
      orow_next      = orow_reg;
      ocol_next      = ocol_reg;
      kr_next        = kr_reg;
      kc_next        = kc_reg;
      max_next       = max_reg;
      pool_data_next = pool_data_reg;
      pool_addr_next = pool_addr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               c_next    = '0;
               orow_next = '0;
               ocol_next = '0;
               kr_next   = '0;
               kc_next   = '0;
            end
         end
         ST_WAIT: begin
            if (fm_rd_valid) begin
               max_next = max_cand;
               if (win_last) begin
                  // Capture the result now so it holds through and after WRITE.
                  pool_data_next = pooled;
                  pool_addr_next = out_addr;
                  kr_next        = '0;
                  kc_next        = '0;
               end else if (kc_last) begin
                  kc_next = '0;
                  kr_next = kr_reg + 1'b1;
               end else begin
                  kc_next = kc_reg + 1'b1;
               end
            end
         end
         ST_WRITE: begin
            if (ocol_reg == COL_LAST) begin
               ocol_next = '0;
               if (orow_reg == ROW_LAST) begin
                  orow_next = '0;
                  c_next    = (c_reg == C_LAST) ? '0 : c_reg + 1'b1;
               end else begin
                  orow_next = orow_reg + 1'b1;
               end
            end else begin
               ocol_next = ocol_reg + 1'b1;
            end
         end
         default: begin
            c_next = c_reg;
         end
      endcase
   end

   // Read address for the element selected by the next counter values. It is
   // registered so it is already valid in ISSUE; counters only move on an
   // accepted read or in WRITE, so it stays put for the whole WAIT.
   // Trailing odd rows/columns are never reached because the window origin
   // never exceeds (OW-1)*P / (OH-1)*P.
   always_comb begin
      fm_row_next  = FM_AW'(orow_next) * FM_AW'(POOL_SIZE) + FM_AW'(kr_next);
      fm_col_next  = FM_AW'(ocol_next) * FM_AW'(POOL_SIZE) + FM_AW'(kc_next);
      fm_addr_next = FM_AW'(c_next) * FM_AW'(INPUT_WIDTH * INPUT_HEIGHT) +
                     fm_row_next * FM_AW'(INPUT_WIDTH) + fm_col_next;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         c_reg         <= '0;
         orow_reg      <= '0;
         ocol_reg      <= '0;
         kr_reg        <= '0;
         kc_reg        <= '0;
         max_reg       <= '0;
         pool_data_reg <= '0;
         pool_addr_reg <= '0;
         fm_addr_reg   <= '0;
      end else begin
         c_reg         <= c_next;
         orow_reg      <= orow_next;
         ocol_reg      <= ocol_next;
         kr_reg        <= kr_next;
         kc_reg        <= kc_next;
         max_reg       <= max_next;
         pool_data_reg <= pool_data_next;
         pool_addr_reg <= pool_addr_next;
         fm_addr_reg   <= fm_addr_next;
      end
   end

   assign fm_addr   = fm_addr_reg;
   assign pool_data = pool_data_reg;
   assign pool_addr = pool_addr_reg;

endmodule

// File: tb/tb_maxpool2d.sv
// ---------------------------------------------------------------------------
// tb_maxpool2d
//
// Two instances: dut_a (4x4x1, P=2, raw max) and dut_c (5x5x2, P=2, ReLU).
// Each has a memory responder driven on the falling edge that returns
// mem[addr] after a configurable latency and keeps protocol statistics.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_maxpool2d;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- dut_a ----------------
   logic        start_a = 1'b0;
   logic        rd_en_a;
   logic [3:0]  addr_a;
   logic [15:0] data_a = 16'd0;
   logic        valid_a = 1'b0;
   logic [15:0] pdata_a;
   logic [1:0]  paddr_a;
   logic        pvalid_a, busy_a, done_a;

   maxpool2d #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .NUM_CHANNELS(1),
               .POOL_SIZE(2), .RELU(0)) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .fm_rd_en(rd_en_a), .fm_addr(addr_a), .fm_data(data_a),
      .fm_rd_valid(valid_a), .pool_data(pdata_a), .pool_addr(paddr_a),
      .pool_valid(pvalid_a), .busy(busy_a), .done(done_a));

   // ---------------- dut_c ----------------
   logic        start_c = 1'b0;
   logic        rd_en_c;
   logic [5:0]  addr_c;
   logic [15:0] data_c = 16'd0;
   logic        valid_c = 1'b0;
   logic [15:0] pdata_c;
   logic [2:0]  paddr_c;
   logic        pvalid_c, busy_c, done_c;

   maxpool2d #(.INPUT_WIDTH(5), .INPUT_HEIGHT(5), .NUM_CHANNELS(2),
               .POOL_SIZE(2), .RELU(1)) dut_c (
      .clk(clk), .reset(reset), .start(start_c),
      .fm_rd_en(rd_en_c), .fm_addr(addr_c), .fm_data(data_c),
      .fm_rd_valid(valid_c), .pool_data(pdata_c), .pool_addr(paddr_c),
      .pool_valid(pvalid_c), .busy(busy_c), .done(done_c));

   // ---------------- responder / monitor A ----------------
   logic [15:0] mem_a [16];
   bit          lat_rand_a = 1'b0;
   bit          spur_a = 1'b0;
   int          cnt_a = 0;
   logic [3:0]  hold_a = 4'd0;
   int          viol_out_a = 0, viol_hold_a = 0, rd_cnt_a = 0;
   logic [15:0] pd_a [64];
   logic [1:0]  pa_a [64];
   int          np_a = 0, done_cnt_a = 0, done_cyc_a = 0;
   logic        first_rd_a;

   always @(negedge clk) begin
      valid_a = 1'b0;
      if (reset) begin
         cnt_a = 0;
      end else if (rd_en_a) begin
         if (cnt_a != 0) viol_out_a++;
         rd_cnt_a++;
         hold_a = addr_a;
         if (lat_rand_a) begin
            case ($urandom_range(0, 2))
               0:       cnt_a = 1;
               1:       cnt_a = 3;
               default: cnt_a = 7;
            endcase
         end else begin
            cnt_a = 1;
         end
         if (spur_a) begin
            valid_a = 1'b1;
            data_a  = 16'h7FFF;
         end
      end else if (cnt_a > 0) begin
         if (addr_a !== hold_a) viol_hold_a++;
         cnt_a--;
         if (cnt_a == 0) begin
            valid_a = 1'b1;
            data_a  = mem_a[hold_a];
         end
      end else if (spur_a) begin
         valid_a = 1'b1;
         data_a  = 16'h7FFF;
      end
      if (pvalid_a && np_a < 64) begin
         pd_a[np_a] = pdata_a;
         pa_a[np_a] = paddr_a;
         np_a++;
      end
      if (done_a) begin
         done_cnt_a++;
         done_cyc_a = cyc;
      end
   end

   // ---------------- responder / monitor C (latency 1) ----------------
   logic [15:0] mem_c [50];
   int          cnt_c = 0;
   logic [5:0]  hold_c = 6'd0;
   int          viol_out_c = 0, viol_hold_c = 0, rd_cnt_c = 0;
   logic [5:0]  rd_log_c [64];
   logic [15:0] pd_c [16];
   logic [2:0]  pa_c [16];
   int          np_c = 0, done_cnt_c = 0, done_cyc_c = 0;

   always @(negedge clk) begin
      valid_c = 1'b0;
      if (reset) begin
         cnt_c = 0;
      end else if (rd_en_c) begin
         if (cnt_c != 0) viol_out_c++;
         if (rd_cnt_c < 64) rd_log_c[rd_cnt_c] = addr_c;
         rd_cnt_c++;
         hold_c = addr_c;
         cnt_c  = 1;
      end else if (cnt_c > 0) begin
         if (addr_c !== hold_c) viol_hold_c++;
         cnt_c--;
         if (cnt_c == 0) begin
            valid_c = 1'b1;
            data_c  = mem_c[hold_c];
         end
      end
      if (pvalid_c && np_c < 16) begin
         pd_c[np_c] = pdata_c;
         pa_c[np_c] = paddr_c;
         np_c++;
      end
      if (done_c) begin
         done_cnt_c++;
         done_cyc_c = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Stimulus helper: one pass on dut_a, optionally pulsing start while busy.
   task automatic run_a(input bit extra_starts, output int t0, output bit timed_out);
      @(negedge clk);
      start_a = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start_a    = 1'b0;
      first_rd_a = rd_en_a;
      timed_out  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt_a != 0 && done_cyc_a >= t0) begin
            timed_out = 1'b0;
            break;
         end
         if (extra_starts) start_a = (((cyc - t0) % 4) == 2) && ((cyc - t0) < 30);
         @(negedge clk);
      end
      start_a = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_ramp_a();
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy_a, pvalid_a, done_a, rd_en_a} !== 4'b0) begin
         n_err++; $display("FAIL reset_ctrl_a: got %b want 0000", {busy_a, pvalid_a, done_a, rd_en_a});
      end
      n_vec++;
      if ({addr_a, pdata_a, paddr_a} !== 22'd0) begin
         n_err++; $display("FAIL reset_data_a: got %h want 0", {addr_a, pdata_a, paddr_a});
      end
      n_vec++;
      if ({busy_c, pvalid_c, done_c, rd_en_c, addr_c, pdata_c, paddr_c} !== 29'd0) begin
         n_err++; $display("FAIL reset_c: got %h want 0", {busy_c, pvalid_c, done_c, rd_en_c, addr_c, pdata_c, paddr_c});
      end
      $display("reset: outputs sampled");
      reset = 1'b0;
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------
   task automatic test_basic();
      int t0, b_np, b_dn, b_rd, b_vo, b_vh;
      bit to;
      logic [15:0] exp_d [4];
      exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
      fill_ramp_a();
      lat_rand_a = 1'b0; spur_a = 1'b0;
      b_np = np_a; b_dn = done_cnt_a; b_rd = rd_cnt_a; b_vo = viol_out_a; b_vh = viol_hold_a;
      run_a(1'b0, t0, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL basic_timeout: no done within budget"); end
      n_vec++;
      if (first_rd_a !== 1'b1) begin
         n_err++; $display("FAIL basic_first_rd: fm_rd_en one cycle after start got %b want 1", first_rd_a);
      end
      n_vec++;
      if (np_a - b_np !== 4) begin n_err++; $display("FAIL basic_count: got %0d writes want 4", np_a - b_np); end
      for (int k = 0; k < 4; k++) begin
         $display("basic: pool addr=%0d data=%h", pa_a[b_np+k], pd_a[b_np+k]);
         n_vec++;
         if (pd_a[b_np+k] !== exp_d[k] || pa_a[b_np+k] !== 2'(k)) begin
            n_err++; $display("FAIL basic_out%0d: got addr %0d data %h want addr %0d data %h",
                              k, pa_a[b_np+k], pd_a[b_np+k], k, exp_d[k]);
         end
      end
      n_vec++;
      if (done_cnt_a - b_dn !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt_a - b_dn); end
      n_vec++;
      if (done_cyc_a - t0 !== 36) begin n_err++; $display("FAIL basic_latency: got %0d cycles want 36", done_cyc_a - t0); end
      n_vec++;
      if (rd_cnt_a - b_rd !== 16) begin n_err++; $display("FAIL basic_reads: got %0d want 16", rd_cnt_a - b_rd); end
      n_vec++;
      if ((viol_out_a - b_vo) !== 0 || (viol_hold_a - b_vh) !== 0) begin
         n_err++; $display("FAIL basic_protocol: outstanding %0d addr_moves %0d want 0 0", viol_out_a - b_vo, viol_hold_a - b_vh);
      end
      n_vec++;
      if (busy_a !== 1'b0 || pdata_a !== 16'd15 || paddr_a !== 2'd3) begin
         n_err++; $display("FAIL basic_hold: busy %b data %h addr %0d want 0 000f 3", busy_a, pdata_a, paddr_a);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_negative_raw();
      int t0, b_np;
      bit to;
      logic [15:0] exp_d [4];
      mem_a = '{16'hFFFD, 16'hFFFF, 16'hFFFB, 16'h0004,
                16'hFFF8, 16'hFFFE, 16'h0000, 16'h0003,
                16'h0007, 16'h0002, 16'h8000, 16'h8000,
                16'h0007, 16'hFFFF, 16'h8000, 16'h8001};
      exp_d = '{16'hFFFF, 16'h0004, 16'h0007, 16'h8001};
      b_np = np_a;
      run_a(1'b0, t0, to);
      n_vec++;
      if (to || np_a - b_np !== 4) begin n_err++; $display("FAIL neg_count: got %0d writes timeout %b want 4", np_a - b_np, to); end
      for (int k = 0; k < 4; k++) begin
         $display("neg_raw: pool addr=%0d data=%h", pa_a[b_np+k], pd_a[b_np+k]);
         n_vec++;
         if (pd_a[b_np+k] !== exp_d[k]) begin
            n_err++; $display("FAIL neg_raw%0d: got %h want %h", k, pd_a[b_np+k], exp_d[k]);
         end
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_multichannel_relu();
      int t0, bad;
      bit to;
      logic [15:0] exp_d [8];
      exp_d = '{16'd0, 16'd4, 16'd16, 16'd18, 16'd31, 16'd33, 16'd41, 16'd43};
      for (int i = 0; i < 50; i++) begin
         if (((i % 25) / 5) == 4 || (i % 5) == 4) mem_c[i] = 16'h7000;
         else mem_c[i] = 16'(i);
      end
      mem_c[0] = 16'hFFFD; mem_c[1] = 16'hFFFF; mem_c[5] = 16'hFFF8; mem_c[6] = 16'hFFFE;
      mem_c[2] = 16'hFFFB; mem_c[3] = 16'h0004; mem_c[7] = 16'h0000; mem_c[8] = 16'h0003;
      @(negedge clk);
      start_c = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start_c = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt_c != 0) begin to = 1'b0; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (to || np_c !== 8) begin n_err++; $display("FAIL mc_count: got %0d writes timeout %b want 8", np_c, to); end
      for (int k = 0; k < 8; k++) begin
         $display("multich: pool addr=%0d data=%h", pa_c[k], pd_c[k]);
         n_vec++;
         if (pd_c[k] !== exp_d[k] || pa_c[k] !== 3'(k)) begin
            n_err++; $display("FAIL mc_out%0d: got addr %0d data %h want addr %0d data %h", k, pa_c[k], pd_c[k], k, exp_d[k]);
         end
      end
      n_vec++;
      if (rd_cnt_c !== 32) begin n_err++; $display("FAIL mc_reads: got %0d want 32", rd_cnt_c); end
      n_vec++;
      if (rd_log_c[16] !== 6'd25) begin n_err++; $display("FAIL mc_ch1_base: got %0d want 25", rd_log_c[16]); end
      bad = 0;
      for (int k = 0; k < 32 && k < rd_cnt_c; k++) begin
         if (rd_log_c[k] >= 6'd50 || ((rd_log_c[k] % 25) % 5) == 4 || ((rd_log_c[k] % 25) / 5) == 4) bad++;
      end
      n_vec++;
      if (bad !== 0) begin n_err++; $display("FAIL mc_trailing: got %0d reads of trailing row/col want 0", bad); end
      n_vec++;
      if (done_cnt_c !== 1 || done_cyc_c - t0 !== 72) begin
         n_err++; $display("FAIL mc_done: got count %0d at %0d cycles want 1 at 72", done_cnt_c, done_cyc_c - t0);
      end
      n_vec++;
      if (viol_out_c !== 0 || viol_hold_c !== 0) begin
         n_err++; $display("FAIL mc_protocol: outstanding %0d addr_moves %0d want 0 0", viol_out_c, viol_hold_c);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_variable_latency();
      int t0, b_np, b_vo, b_vh;
      bit to;
      logic [15:0] exp_d [4];
      exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
      fill_ramp_a();
      lat_rand_a = 1'b1;
      b_np = np_a; b_vo = viol_out_a; b_vh = viol_hold_a;
      run_a(1'b0, t0, to);
      lat_rand_a = 1'b0;
      n_vec++;
      if (to || np_a - b_np !== 4) begin n_err++; $display("FAIL lat_count: got %0d writes timeout %b want 4", np_a - b_np, to); end
      for (int k = 0; k < 4; k++) begin
         $display("latency: pool addr=%0d data=%h", pa_a[b_np+k], pd_a[b_np+k]);
         n_vec++;
         if (pd_a[b_np+k] !== exp_d[k] || pa_a[b_np+k] !== 2'(k)) begin
            n_err++; $display("FAIL lat_out%0d: got addr %0d data %h want addr %0d data %h", k, pa_a[b_np+k], pd_a[b_np+k], k, exp_d[k]);
         end
      end
      n_vec++;
      if ((viol_out_a - b_vo) !== 0 || (viol_hold_a - b_vh) !== 0) begin
         n_err++; $display("FAIL lat_protocol: outstanding %0d addr_moves %0d want 0 0", viol_out_a - b_vo, viol_hold_a - b_vh);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_pass();
      int t0, b_np;
      bit to;
      logic [15:0] exp_d [4];
      exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
      fill_ramp_a();
      b_np = np_a;
      @(negedge clk);
      start_a = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start_a = 1'b0;
      while (cyc < t0 + 10) @(negedge clk);
      // Second window, first element, read outstanding.
      n_vec++;
      if (busy_a !== 1'b1 || rd_en_a !== 1'b0 || np_a - b_np !== 1) begin
         n_err++; $display("FAIL rst_pre: busy %b rd_en %b writes %0d want 1 0 1", busy_a, rd_en_a, np_a - b_np);
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({busy_a, pvalid_a, done_a, rd_en_a} !== 4'b0) begin
         n_err++; $display("FAIL rst_ctrl: got %b want 0000", {busy_a, pvalid_a, done_a, rd_en_a});
      end
      n_vec++;
      if ({addr_a, pdata_a, paddr_a} !== 22'd0) begin
         n_err++; $display("FAIL rst_data: got %h want 0", {addr_a, pdata_a, paddr_a});
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if (np_a - b_np !== 1) begin n_err++; $display("FAIL rst_partial: got %0d writes want 1", np_a - b_np); end
      $display("reset_mid: pass aborted, restarting");
      b_np = np_a;
      run_a(1'b0, t0, to);
      n_vec++;
      if (to || np_a - b_np !== 4) begin n_err++; $display("FAIL rst_rerun_count: got %0d writes timeout %b want 4", np_a - b_np, to); end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (pd_a[b_np+k] !== exp_d[k] || pa_a[b_np+k] !== 2'(k)) begin
            n_err++; $display("FAIL rst_rerun%0d: got addr %0d data %h want addr %0d data %h", k, pa_a[b_np+k], pd_a[b_np+k], k, exp_d[k]);
         end
      end
      n_vec++;
      if (done_cyc_a - t0 !== 36) begin n_err++; $display("FAIL rst_rerun_latency: got %0d want 36", done_cyc_a - t0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back_start_spurious();
      int t0, b_np, b_dn;
      bit to;
      logic [15:0] exp_d [4];
      exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
      fill_ramp_a();
      spur_a = 1'b1;
      b_np = np_a; b_dn = done_cnt_a;
      run_a(1'b1, t0, to);
      spur_a = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (to || np_a - b_np !== 4) begin n_err++; $display("FAIL busy_count: got %0d writes timeout %b want 4", np_a - b_np, to); end
      for (int k = 0; k < 4; k++) begin
         $display("spurious: pool addr=%0d data=%h", pa_a[b_np+k], pd_a[b_np+k]);
         n_vec++;
         if (pd_a[b_np+k] !== exp_d[k] || pa_a[b_np+k] !== 2'(k)) begin
            n_err++; $display("FAIL busy_out%0d: got addr %0d data %h want addr %0d data %h", k, pa_a[b_np+k], pd_a[b_np+k], k, exp_d[k]);
         end
      end
      n_vec++;
      if (done_cnt_a - b_dn !== 1 || done_cyc_a - t0 !== 36) begin
         n_err++; $display("FAIL busy_done: got count %0d at %0d cycles want 1 at 36", done_cnt_a - b_dn, done_cyc_a - t0);
      end
      n_vec++;
      if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_idle: busy %b want 0", busy_a); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative_raw();
      test_multichannel_relu();
      test_variable_latency();
      test_reset_mid_pass();
      test_back_to_back_start_spurious();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
